// File: rtl/otter_intc_pkg.sv
// Shared types and defaults for the otter_intc interrupt controller.
//   - INTC_BASE_ADDR : default byte address of register 0 (16-byte window)
//   - intc_reg_e     : register selected by bus_addr[3:2]
//   - strb_to_mask   : expands 4 byte-lane strobes into a 32-bit bit mask
package otter_intc_pkg;

  localparam logic [31:0] INTC_BASE_ADDR = 32'h1100_0100;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_EDGE    = 2'd2,
    REG_CLAIM   = 2'd3
  } intc_reg_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/otter_intc_sync_edge.sv
// Per-source synchroniser with rising-edge detect.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_src   : asynchronous interrupt source
//   o_s     : synchronised level (last synchroniser stage)
//   o_rise  : one-cycle pulse when o_s goes 0 -> 1
// The prev flop resets to 0, so a source held high across reset is seen
// as one rising edge once it emerges from the synchroniser.
module otter_intc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  output logic o_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/otter_intc.sv
// Memory-mapped interrupt controller driving the MCU's single intrpt input.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-low reset
//   src_irq    : N_SRC asynchronous interrupt sources
//   bus_addr   : byte address (dmem_addr); window is 16 bytes at BASE_ADDR
//   bus_r_en   : read strobe
//   bus_w_en   : write strobe
//   bus_w_strb : byte lanes for writes
//   bus_w_data : write data
//   bus_r_data : registered read data (0 when not selected)
//   bus_sel    : registered; high when bus_r_data belongs to this block
//   intrpt     : registered level request, |(PENDING & ENABLE)
// Registers (word offset): 0x0 PENDING (R, W1C edge bits), 0x4 ENABLE (R/W),
// 0x8 EDGE (R/W, 1 = rising edge), 0xC CLAIM (R, id+1 of lowest active bit;
// the read clears that bit if it is edge mode).
module otter_intc
  import otter_intc_pkg::*;
#(
  parameter int unsigned N_SRC       = 8,
  parameter logic [31:0] BASE_ADDR   = INTC_BASE_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      bus_addr,
  input  logic             bus_r_en,
  input  logic             bus_w_en,
  input  logic [3:0]       bus_w_strb,
  input  logic [31:0]      bus_w_data,
  output logic [31:0]      bus_r_data,
  output logic             bus_sel,
  output logic             intrpt
);

  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_edge;
  logic [31:0]      r_bus_r_data;
  logic             r_bus_sel;
  logic             r_intrpt;

  logic [N_SRC-1:0] w_s;
  logic [N_SRC-1:0] w_rise;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    otter_intc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_src   (src_irq[g]),
      .o_s     (w_s[g]),
      .o_rise  (w_rise[g])
    );
  end

  // Bus decode
  logic       w_hit;
  logic       w_wr;
  logic       w_rd;
  intc_reg_e  w_reg;
  logic [31:0] w_bmask;
  logic [N_SRC-1:0] w_wmask;
  logic [N_SRC-1:0] w_wbits;

  assign w_hit   = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr    = bus_w_en & w_hit;
  assign w_rd    = bus_r_en & w_hit;
  assign w_reg   = intc_reg_e'(bus_addr[3:2]);
  assign w_bmask = strb_to_mask(bus_w_strb);
  assign w_wmask = w_bmask[N_SRC-1:0];
  assign w_wbits = bus_w_data[N_SRC-1:0] & w_wmask;

  // Priority encoder: lowest index of PENDING & ENABLE wins
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_claim_oh;
  logic [5:0]       w_claim_id;
  logic             w_found;

  assign w_active = r_pending & r_enable;

  always_comb begin
    w_claim_oh = '0;
    w_claim_id = '0;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (w_active[i] && !w_found) begin
        w_found       = 1'b1;
        w_claim_id    = 6'(i + 1);
        w_claim_oh[i] = 1'b1;
      end
    end
  end

  // PENDING next state. Edge bits: a rise beats any clear arriving in the
  // same cycle. Level bits simply follow the synchronised source, so W1C
  // and CLAIM cannot touch them.
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_claim_clr;
  logic [N_SRC-1:0] w_pending_nxt;

  assign w_w1c       = (w_wr && (w_reg == REG_PENDING)) ? w_wbits : '0;
  assign w_claim_clr = (w_rd && (w_reg == REG_CLAIM)) ? w_claim_oh : '0;

  always_comb begin
    w_pending_nxt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (r_edge[i]) begin
        w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~w_w1c[i] & ~w_claim_clr[i]);
      end else begin
        w_pending_nxt[i] = w_s[i];
      end
    end
  end

  // Read mux uses current (pre-write) register state
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_PENDING: w_rdata[N_SRC-1:0] = r_pending;
      REG_ENABLE:  w_rdata[N_SRC-1:0] = r_enable;
      REG_EDGE:    w_rdata[N_SRC-1:0] = r_edge;
      REG_CLAIM:   w_rdata[5:0]       = w_claim_id;
      default:     w_rdata            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending    <= '0;
      r_enable     <= '0;
      r_edge       <= '0;
      r_bus_r_data <= '0;
      r_bus_sel    <= 1'b0;
      r_intrpt     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_wr && (w_reg == REG_ENABLE)) begin
        r_enable <= (r_enable & ~w_wmask) | w_wbits;
      end
      if (w_wr && (w_reg == REG_EDGE)) begin
        r_edge <= (r_edge & ~w_wmask) | w_wbits;
      end
      r_bus_r_data <= w_rd ? w_rdata : '0;
      r_bus_sel    <= w_rd;
      r_intrpt     <= |(r_pending & r_enable);
    end
  end

  assign bus_r_data = r_bus_r_data;
  assign bus_sel    = r_bus_sel;
  assign intrpt     = r_intrpt;

  // Address bits [1:0], data/strobe lanes above N_SRC are don't-care
  logic w_unused;
  assign w_unused = &{1'b0, bus_addr[1:0], bus_w_data, w_bmask};

endmodule

// File: tb/tb_otter_intc.sv
module tb_otter_intc;

  localparam logic [31:0] BASE    = 32'h1100_0100;
  localparam logic [31:0] A_PEND  = BASE + 32'h0;
  localparam logic [31:0] A_EN    = BASE + 32'h4;
  localparam logic [31:0] A_EDGE  = BASE + 32'h8;
  localparam logic [31:0] A_CLAIM = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  src_irq = '0;
  logic [31:0] bus_addr = '0;
  logic        bus_r_en = 1'b0;
  logic        bus_w_en = 1'b0;
  logic [3:0]  bus_w_strb = '0;
  logic [31:0] bus_w_data = '0;
  logic [31:0] bus_r_data;
  logic        bus_sel;
  logic        intrpt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  otter_intc #(
    .N_SRC(8),
    .BASE_ADDR(32'h1100_0100),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .src_irq(src_irq),
    .bus_addr(bus_addr), .bus_r_en(bus_r_en), .bus_w_en(bus_w_en),
    .bus_w_strb(bus_w_strb), .bus_w_data(bus_w_data),
    .bus_r_data(bus_r_data), .bus_sel(bus_sel), .intrpt(intrpt)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_sel);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.strb = strb; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_sel = exp_sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a negedge.
  task automatic bus_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    bus_addr = addr; bus_w_strb = strb; bus_w_data = data; bus_w_en = 1'b1;
    @(negedge clk);
    bus_w_en = 1'b0; bus_w_strb = '0; bus_w_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic sel);
    bus_addr = addr; bus_r_en = 1'b1;
    @(negedge clk);
    data = bus_r_data; sel = bus_sel;
    bus_r_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        s;
    bus_read(addr, d, s);
    check({name, " data"}, d, exp);
    check({name, " sel"}, {31'b0, s}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        s;

    vecs[0]  = mk(1, 0, A_EN,            4'hF,    32'h0000_0000, 32'h0,  0);
    vecs[1]  = mk(1, 0, A_EN,            4'b0010, 32'h0000_FF00, 32'h0,  0);
    vecs[2]  = mk(0, 1, A_EN,            4'h0,    32'h0,         32'h0,  1);
    vecs[3]  = mk(1, 0, A_EN,            4'b0001, 32'h1234_5633, 32'h0,  0);
    vecs[4]  = mk(0, 1, A_EN,            4'h0,    32'h0,         32'h33, 1);
    vecs[5]  = mk(1, 0, A_EN,            4'b1110, 32'hFFFF_FFFF, 32'h0,  0);
    vecs[6]  = mk(0, 1, A_EN,            4'h0,    32'h0,         32'h33, 1);
    vecs[7]  = mk(0, 1, BASE + 32'h10,   4'h0,    32'h0,         32'h0,  0);
    vecs[8]  = mk(0, 1, BASE - 32'h4,    4'h0,    32'h0,         32'h0,  0);
    vecs[9]  = mk(1, 0, BASE + 32'h14,   4'hF,    32'h0000_00FF, 32'h0,  0);
    vecs[10] = mk(0, 1, A_EN,            4'h0,    32'h0,         32'h33, 1);
    vecs[11] = mk(0, 1, BASE + 32'h7,    4'h0,    32'h0,         32'h33, 1);
    vecs[12] = mk(1, 0, A_EDGE,          4'hF,    32'h0000_000F, 32'h0,  0);
    vecs[13] = mk(1, 1, A_EDGE,          4'hF,    32'h0000_00F0, 32'h0F, 1);
    vecs[14] = mk(0, 1, A_EDGE,          4'h0,    32'h0,         32'hF0, 1);
    vecs[15] = mk(0, 1, A_CLAIM,         4'h0,    32'h0,         32'h0,  1);
    vecs[16] = mk(0, 1, A_PEND,          4'h0,    32'h0,         32'h0,  1);
    vecs[17] = mk(1, 0, A_EN,            4'hF,    32'hFFFF_FFFF, 32'h0,  0);
    vecs[18] = mk(0, 1, A_EN,            4'h0,    32'h0,         32'hFF, 1);

    // 1. Reset held with all sources high; reads during reset return 0
    rst = 1'b0; src_irq = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(i * 4), d, s);
      check($sformatf("rst read%0d data", i), d, 32'h0);
      check($sformatf("rst read%0d sel", i), {31'b0, s}, 32'h0);
    end
    check("rst intrpt", {31'b0, intrpt}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    read_check("level after rst", A_PEND, 32'hFF);
    check("no intrpt enable=0", {31'b0, intrpt}, 32'h0);
    src_irq = '0;
    repeat (5) @(negedge clk);
    read_check("level dropped", A_PEND, 32'h00);

    // 2. Edge latency and W1C
    bus_write(A_EDGE, 4'hF, 32'hFF);
    bus_write(A_EN, 4'hF, 32'h04);
    src_irq = 8'h04;
    @(negedge clk);
    src_irq = 8'h00;
    repeat (2) @(negedge clk);
    check("edge intrpt +3", {31'b0, intrpt}, 32'h0);
    read_check("edge pend +3", A_PEND, 32'h04);
    check("edge intrpt +4", {31'b0, intrpt}, 32'h1);
    bus_write(A_PEND, 4'hF, 32'h04);
    check("w1c intrpt +1", {31'b0, intrpt}, 32'h1);
    @(negedge clk);
    check("w1c intrpt +2", {31'b0, intrpt}, 32'h0);

    // 3. Claim priority
    bus_write(A_EN, 4'hF, 32'hFF);
    src_irq = 8'h22;
    @(negedge clk);
    src_irq = 8'h00;
    repeat (3) @(negedge clk);
    check("claim intrpt", {31'b0, intrpt}, 32'h1);
    read_check("claim1", A_CLAIM, 32'd2);
    read_check("claim2", A_CLAIM, 32'd6);
    read_check("claim3", A_CLAIM, 32'd0);
    read_check("claim pend", A_PEND, 32'h0);
    check("claim intrpt low", {31'b0, intrpt}, 32'h0);

    // 4. Level mode ignores W1C and CLAIM
    bus_write(A_EDGE, 4'hF, 32'h00);
    bus_write(A_EN, 4'hF, 32'h01);
    src_irq = 8'h01;
    repeat (5) @(negedge clk);
    check("level intrpt", {31'b0, intrpt}, 32'h1);
    bus_write(A_PEND, 4'hF, 32'h01);
    repeat (2) @(negedge clk);
    check("level w1c intrpt", {31'b0, intrpt}, 32'h1);
    read_check("level w1c pend", A_PEND, 32'h01);
    read_check("level claim", A_CLAIM, 32'd1);
    read_check("level claim pend", A_PEND, 32'h01);
    src_irq = 8'h00;
    repeat (3) @(negedge clk);
    check("level drop +3", {31'b0, intrpt}, 32'h1);
    @(negedge clk);
    check("level drop +4", {31'b0, intrpt}, 32'h0);

    // 5. Edge set collides with W1C of the same bit: set wins
    bus_write(A_EDGE, 4'hF, 32'hFF);
    bus_write(A_EN, 4'hF, 32'h08);
    src_irq = 8'h08;
    @(negedge clk);
    src_irq = 8'h00;
    @(negedge clk);
    bus_write(A_PEND, 4'hF, 32'h08);
    read_check("collision pend", A_PEND, 32'h08);
    check("collision intrpt", {31'b0, intrpt}, 32'h1);

    // Reset asserted while a read is in flight
    rst = 1'b0; bus_addr = A_EN; bus_r_en = 1'b1;
    @(negedge clk);
    check("rst mid read data", bus_r_data, 32'h0);
    check("rst mid read sel", {31'b0, bus_sel}, 32'h0);
    check("rst mid intrpt", {31'b0, intrpt}, 32'h0);
    bus_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    read_check("post rst enable", A_EN, 32'h0);
    read_check("post rst edge", A_EDGE, 32'h0);

    // 6. Bus decode / strobes / masking table
    for (int i = 0; i < 19; i++) begin
      bus_addr = vecs[i].addr; bus_w_strb = vecs[i].strb; bus_w_data = vecs[i].wdata;
      bus_w_en = vecs[i].wr;   bus_r_en = vecs[i].rd;
      @(negedge clk);
      bus_w_en = 1'b0; bus_r_en = 1'b0;
      check($sformatf("vec%0d data", i), bus_r_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d sel", i), {31'b0, bus_sel}, {31'b0, vecs[i].exp_sel});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
